// File: rtl/hsp_ram_pkg.sv
// Shared definitions for the RAM port arbiter slice.
//   state_e         : arbiter FSM state encoding
//   RdLatencyMin/Max: legal range of the RAM read latency parameter
//   LatCntW         : width of the read-latency counter
//   DefaultAddrW/W  : default address / data bus widths
package hsp_ram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdIssue,
        StRdWait,
        StRdDone
    } state_e;

    localparam int unsigned RdLatencyMin = 1;
    localparam int unsigned RdLatencyMax = 4;
    localparam int unsigned LatCntW      = $clog2(RdLatencyMax);

    localparam int unsigned DefaultAddrW = 16;
    localparam int unsigned DefaultDataW = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a registered last-served pointer.
// Ports:
//   clk, rst_l : clock, asynchronous active-low reset
//   req_wr     : write side is eligible this cycle
//   req_rd     : read side is eligible this cycle
//   grant_wr   : write granted (combinational, one-hot with grant_rd or zero)
//   grant_rd   : read granted
// The pointer resets to "read served last" so the first tie goes to write.
module rr_arb2 (
    input  logic clk,
    input  logic rst_l,
    input  logic req_wr,
    input  logic req_rd,
    output logic grant_wr,
    output logic grant_rd
);

    logic last_rd_q, last_rd_d;

    always_comb begin
        grant_wr  = req_wr & (~req_rd | last_rd_q);
        grant_rd  = req_rd & (~req_wr | ~last_rd_q);
        last_rd_d = last_rd_q;
        if (grant_wr) begin
            last_rd_d = 1'b0;
        end else if (grant_rd) begin
            last_rd_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            last_rd_q <= 1'b1;
        end else begin
            last_rd_q <= last_rd_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates a single-port RAM between a write requester (protocol RX) and a
// read requester (protocol TX). One RAM access per granted transaction.
// Ports:
//   clk, rst_l                  : clock, asynchronous active-low reset
//   wr_req, wr_addr, wr_data    : write request, held until wr_rdy
//   wr_rdy                      : one-cycle write-done pulse
//   rd_req, rd_addr             : read request, held until rd_rdy
//   rd_data, rd_rdy             : read data (held) and one-cycle read-done pulse
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata        : RAM port
//   busy                        : FSM is not idle
// Timing (grant sampled in cycle N):
//   write: RAM access N+1, wr_rdy N+2, next grant possible N+3
//   read : RAM access N+1, wait RD_LATENCY cycles, rd_rdy N+2+RD_LATENCY
module ram_port_arbiter
    import hsp_ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefaultAddrW,
    parameter int unsigned DATA_W     = DefaultDataW,
    // Must lie in RdLatencyMin..RdLatencyMax.
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_rdy,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_rdy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [LatCntW-1:0] LatLast = LatCntW'(RD_LATENCY - 1);

    state_e              state_q, state_d;
    logic [LatCntW-1:0]  lat_cnt_q, lat_cnt_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                wr_rdy_q, wr_rdy_d;
    logic                rd_rdy_q, rd_rdy_d;
    logic                wr_armed_q, wr_armed_d;
    logic                rd_armed_q, rd_armed_d;
    logic                wr_elig, rd_elig;
    logic                grant_wr, grant_rd;

    // Eligibility only exists in idle, so the arbiter pointer moves on real grants only.
    assign wr_elig = wr_req & wr_armed_q & (state_q == StIdle);
    assign rd_elig = rd_req & rd_armed_q & (state_q == StIdle);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_l    (rst_l),
        .req_wr   (wr_elig),
        .req_rd   (rd_elig),
        .grant_wr (grant_wr),
        .grant_rd (grant_rd)
    );

    // Armed flag: cleared by the rdy pulse, re-set once req is seen low, so a
    // requester that keeps req high after completion is not served twice.
    always_comb begin
        wr_armed_d = wr_armed_q;
        rd_armed_d = rd_armed_q;
        if (wr_rdy_q) begin
            wr_armed_d = 1'b0;
        end else if (!wr_req) begin
            wr_armed_d = 1'b1;
        end
        if (rd_rdy_q) begin
            rd_armed_d = 1'b0;
        end else if (!rd_req) begin
            rd_armed_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rd_data_d   = rd_data_q;
        wr_rdy_d    = 1'b0;
        rd_rdy_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    state_d     = StWr;
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = wr_addr;
                    ram_wdata_d = wr_data;
                end else if (grant_rd) begin
                    state_d    = StRdIssue;
                    ram_en_d   = 1'b1;
                    ram_addr_d = rd_addr;
                end
            end
            // WR spans two cycles: the RAM write, then the wr_rdy cycle.
            StWr: begin
                if (ram_en_q) begin
                    wr_rdy_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StRdIssue: begin
                state_d   = StRdWait;
                lat_cnt_d = '0;
            end
            StRdWait: begin
                if (lat_cnt_q == LatLast) begin
                    rd_data_d = ram_rdata;
                    rd_rdy_d  = 1'b1;
                    state_d   = StRdDone;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatCntW'(1);
                end
            end
            StRdDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= StIdle;
            lat_cnt_q   <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_data_q   <= '0;
            wr_rdy_q    <= 1'b0;
            rd_rdy_q    <= 1'b0;
            wr_armed_q  <= 1'b1;
            rd_armed_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_data_q   <= rd_data_d;
            wr_rdy_q    <= wr_rdy_d;
            rd_rdy_q    <= rd_rdy_d;
            wr_armed_q  <= wr_armed_d;
            rd_armed_q  <= rd_armed_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rd_data   = rd_data_q;
    assign wr_rdy    = wr_rdy_q;
    assign rd_rdy    = rd_rdy_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a 1-cycle synchronous RAM model.
module tb_ram_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_rdy;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_rdy;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int en_count = 0;
    int rdy_rd_count = 0;
    int overlap_err = 0;
    logic prev_en = 1'b0;

    ram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RD_LATENCY (1)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_rdy    (rd_rdy),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten locations return a fixed pattern, address 3 holds 0xA5.
    logic [DW-1:0] mem [64];
    logic [63:0]   wr_flag = '0;

    function automatic logic [DW-1:0] init_val(input logic [5:0] a);
        return (a == 6'd3) ? 8'hA5 : ({2'b00, a} ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            mem[ram_addr[5:0]]     <= ram_wdata;
            wr_flag[ram_addr[5:0]] <= 1'b1;
        end else if (ram_en) begin
            ram_rdata <= wr_flag[ram_addr[5:0]] ? mem[ram_addr[5:0]] : init_val(ram_addr[5:0]);
        end
    end

    // Activity monitors: RAM enable cycles, read completions, back-to-back enables.
    always @(posedge clk) begin
        if (ram_en) en_count <= en_count + 1;
        if (rd_rdy) rdy_rd_count <= rdy_rd_count + 1;
        if (ram_en && prev_en) overlap_err <= overlap_err + 1;
        prev_en <= ram_en;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the selected rdy pulses; ok=0 if the budget expires.
    task automatic wait_rdy(input bit is_rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (is_rd ? rd_rdy : wr_rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [63:0] outs();
        return {27'b0, wr_rdy, rd_rdy, ram_en, ram_we, busy, rd_data, ram_addr, ram_wdata};
    endfunction

    localparam bit KindWr = 1'b0;
    localparam bit KindRd = 1'b1;
    bit last_kind;

    initial begin
        int base;
        int base_rdy;
        bit ok;
        logic [3:0] tie_exp [7];

        // Reset state
        step();
        check("reset_outs", outs(), 64'd0);
        step();
        rst_l = 1'b1;
        step();
        check("post_reset_idle", outs(), 64'd0);

        // Single write
        step();
        wr_addr = 16'h0010; wr_data = 8'hB6; wr_req = 1'b1;
        step();
        check("wr_n1_ctl", {ram_en, ram_we, wr_rdy}, 3'b110);
        check("wr_n1_addr", ram_addr, 16'h0010);
        check("wr_n1_data", ram_wdata, 8'hB6);
        step();
        check("wr_n2_ctl", {ram_en, ram_we, wr_rdy, busy}, 4'b0011);
        check("wr_n2_hold", {ram_addr, ram_wdata}, {16'h0010, 8'hB6});
        wr_req = 1'b0;
        step();
        check("wr_n3_idle", {wr_rdy, busy}, 2'b00);
        step();

        // Single read; a write request that drops while busy must not access RAM
        step();
        base = en_count;
        rd_addr = 16'h0003; rd_req = 1'b1;
        step();
        check("rd_n1_ctl", {ram_en, ram_we}, 2'b10);
        check("rd_n1_addr", ram_addr, 16'h0003);
        wr_addr = 16'h0030; wr_data = 8'h99; wr_req = 1'b1;
        step();
        check("rd_n2_ctl", {ram_en, rd_rdy, busy}, 3'b001);
        step();
        check("rd_n3_rdy", {rd_rdy, rd_data}, {1'b1, 8'hA5});
        wr_req = 1'b0; rd_req = 1'b0;
        step();
        check("rd_n4_hold", {rd_rdy, busy, rd_data}, {2'b00, 8'hA5});
        repeat (3) step();
        check("dropped_wr_no_access", en_count - base, 1);

        // Simultaneous requests after reset: write first, then read
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        step();
        step();
        tie_exp = '{4'b1100, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        wr_addr = 16'h0005; wr_data = 8'h77; wr_req = 1'b1;
        rd_addr = 16'h0005; rd_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            check($sformatf("tie_c%0d", c), {ram_en, ram_we, wr_rdy, rd_rdy}, tie_exp[c-1]);
            if (c == 6) check("tie_rd_data", rd_data, 8'h77);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        step();
        step();

        // Held wr_req: one write only; address/data sampled at grant only
        base = en_count;
        wr_addr = 16'h0021; wr_data = 8'h11; wr_req = 1'b1;
        step();
        wr_addr = 16'h0099; wr_data = 8'hEE;
        check("late_change_ignored", {ram_addr, ram_wdata}, {16'h0021, 8'h11});
        step();
        check("held_wr_rdy", wr_rdy, 1'b1);
        repeat (10) step();
        check("held_no_regrant", {busy, wr_rdy}, 2'b00);
        check("held_one_write", en_count - base, 1);
        wr_req = 1'b0;
        step();
        wr_addr = 16'h0022; wr_data = 8'h22; wr_req = 1'b1;
        wait_rdy(1'b0, ok);
        check("second_wr_done", ok, 1'b1);
        check("second_wr_count", en_count - base, 2);
        check("second_wr_addr", {ram_addr, ram_wdata}, {16'h0022, 8'h22});
        wr_req = 1'b0;
        step();
        step();

        // Reset during RD_WAIT aborts the read
        rd_addr = 16'h0003; rd_req = 1'b1;
        step();
        step();
        #1;
        rst_l = 1'b0; rd_req = 1'b0;
        #1;
        check("rst_mid_outs_zero", outs(), 64'd0);
        base_rdy = rdy_rd_count;
        base = en_count;
        step();
        step();
        rst_l = 1'b1;
        repeat (4) step();
        check("rst_no_rd_rdy", rdy_rd_count - base_rdy, 0);
        check("rst_no_ram_en", en_count - base, 0);
        rd_addr = 16'h0003; rd_req = 1'b1;
        wait_rdy(1'b1, ok);
        check("post_rst_rd_done", ok, 1'b1);
        check("post_rst_rd_data", rd_data, 8'hA5);
        rd_req = 1'b0;
        step();
        step();

        // Saturating alternating traffic, 8 writes and 8 reads
        last_kind = KindRd;
        fork
            begin
                bit wok;
                for (int i = 0; i < 8; i++) begin
                    wr_addr = 16'h0010 + AW'(i); wr_data = 8'hC0 + DW'(i); wr_req = 1'b1;
                    wait_rdy(1'b0, wok);
                    check($sformatf("alt_wr%0d_done", i), wok, 1'b1);
                    check($sformatf("alt_wr%0d_order", i), last_kind, KindRd);
                    last_kind = KindWr;
                    wr_req = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                end
            end
            begin
                bit rok;
                for (int i = 0; i < 8; i++) begin
                    rd_addr = 16'h0010 + AW'(i); rd_req = 1'b1;
                    wait_rdy(1'b1, rok);
                    check($sformatf("alt_rd%0d_done", i), rok, 1'b1);
                    check($sformatf("alt_rd%0d_order", i), last_kind, KindWr);
                    check($sformatf("alt_rd%0d_data", i), rd_data, 8'hC0 + DW'(i));
                    last_kind = KindRd;
                    rd_req = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                end
            end
        join
        step();
        check("no_ram_overlap", overlap_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the width of every address bus.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the width of every data bus.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, range 1..4, meaning RAM read latency in clk cycles from ram_en to valid ram_rdata.
REQ-004 The block SHALL have one clock, clk, and reset rst_l, which is asynchronous and active-low.
REQ-005 The block SHALL have these ports:
- clk  in  1  sole clock.
- rst_l  in  1  asynchronous active-low reset.
- wr_req  in  1  write request from the protocol RX side.
- wr_addr  in  ADDR_W  write address, held while wr_req is high.
- wr_data  in  DATA_W  write data, held while wr_req is high.
- wr_rdy  out  1  one-cycle pulse: write done.
- rd_req  in  1  read request from the protocol TX side.
- rd_addr  in  ADDR_W  read address, held while rd_req is high.
- rd_data  out  DATA_W  read data, valid while rd_rdy is high and held afterwards.
- rd_rdy  out  1  one-cycle pulse: read done.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-006 The FSM SHALL have exactly these states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE.
REQ-007 In IDLE, a requester SHALL be eligible only when its req is high and its armed flag is set.
REQ-008 When both requesters are eligible in the same cycle, the block SHALL grant the one not served last (round-robin); the last-served pointer SHALL reset to "read", so write wins the first tie.
REQ-009 A write granted at sample cycle N SHALL be performed as follows:
- cycle N+1: ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, for exactly one cycle (state WR).
- cycle N+2: wr_rdy=1 for one cycle; FSM returns to IDLE.
REQ-010 A read granted at sample cycle N SHALL be performed as follows:
- cycle N+1: ram_en=1, ram_we=0, ram_addr=rd_addr, for one cycle (state RD_ISSUE).
- then RD_WAIT for RD_LATENCY cycles.
- ram_rdata SHALL be captured into rd_data at cycle N+1+RD_LATENCY.
- rd_rdy=1 at cycle N+2+RD_LATENCY (state RD_DONE), followed by IDLE.
REQ-011 ram_en, ram_we, ram_addr, ram_wdata, wr_rdy and rd_rdy SHALL be registered outputs.
REQ-012 When ram_en=0, ram_we SHALL be 0; ram_addr and ram_wdata SHALL hold their last values.
REQ-013 After a requester's rdy pulse, its armed flag SHALL clear. The flag SHALL set again only after its req is sampled low, so a req still high in the cycle after rdy is never granted twice.
REQ-014 A request arriving while busy=1 SHALL wait with no loss and SHALL be granted at the first IDLE sample.
REQ-015 The minimum back-to-back service SHALL be:
- write-to-write: every 3 cycles.
- read-to-read: every 3+RD_LATENCY cycles.
REQ-016 A req that drops before its grant SHALL cause no access.
REQ-017 A req that drops after its grant SHALL NOT abort the access, and rdy SHALL still pulse.
REQ-018 Address and data SHALL be sampled at the grant cycle only; later changes SHALL be ignored.
REQ-019 Reads and writes SHALL never overlap on the RAM port; at most one ram_en cycle SHALL occur per granted transaction.

Reset
REQ-020 While rst_l=0, the FSM SHALL be in IDLE and all outputs SHALL be 0; the armed flags SHALL be 1 and the last-served pointer SHALL be "read".
REQ-021 Reset asserted mid-transaction SHALL abort it immediately, with no rdy pulse and no further ram_en.
REQ-022 After reset release, the first grant SHALL occur no earlier than the first rising edge following release.

Structure
REQ-023 The state encoding typedef, the RD_LATENCY bound and the default ADDR_W/DATA_W constants SHALL live in the shared package hsp_ram_pkg.
REQ-024 The tie-break logic SHALL be the sub-module rr_arb2: a 2-input round-robin arbiter with registered last-served pointer, outputs grant_wr and grant_rd, one-hot or zero.
REQ-025 RD_LATENCY SHALL be implemented with a counter, not a shift chain.

Verification
REQ-026 Single write: wr_req=1, wr_addr=0x0010, wr_data=0xB6 sampled at cycle N -> ram_en=ram_we=1, ram_addr=0x0010, ram_wdata=0xB6 at N+1; wr_rdy at N+2 only.
REQ-027 Single read, RD_LATENCY=1, RAM model returning 0xA5 at address 0x0003: rd_req at N -> ram_en=1, ram_we=0 at N+1; rd_rdy=1 with rd_data=0xA5 at N+3.
REQ-028 Simultaneous wr_req and rd_req after reset, both held -> write first (wr_rdy at N+2), then read; rd_rdy at N+6 with RD_LATENCY=1; no overlapping ram_en.
REQ-029 wr_req held high for 10 cycles after wr_rdy -> exactly one RAM write; a second write occurs only after a low-then-high wr_req.
REQ-030 rst_l pulsed low during RD_WAIT -> all outputs 0 immediately; no rd_rdy; a read requested after release completes normally.
REQ-031 Alternating saturating traffic of 8 writes and 8 reads -> strict wr/rd alternation, with a RAM scoreboard match on every rd_data.
